// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams len operand pairs from two sync-read memories
// into an external MAC, waits for the pipeline to drain, then captures the sum.
module mac_dot_seq #(
  parameter int DW      = 16,
  parameter int ACCW    = 36,
  parameter int AW      = 8,
  parameter int MAC_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   base_a,
  input  logic [AW-1:0]   base_b,
  input  logic [AW-1:0]   len,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] result,
  output logic            rd_en,
  output logic [AW-1:0]   addr_a,
  output logic [AW-1:0]   addr_b,
  input  logic [DW-1:0]   rd_data_a,
  input  logic [DW-1:0]   rd_data_b,
  output logic            mac_clr,
  output logic [DW-1:0]   mac_a,
  output logic [DW-1:0]   mac_b,
  input  logic [ACCW-1:0] mac_acc
);

  localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t          state_r;
  state_t          fsm_nxt_s;
  state_t          state_nxt_s;
  logic [AW-1:0]   base_a_r;
  logic [AW-1:0]   base_b_r;
  logic [AW-1:0]   len_r;
  logic [AW-1:0]   rem_r;
  logic [DCW-1:0]  dcnt_r;
  logic            valid_r;
  logic            abort_hit_s;

  // Next-state decode; abort from any busy state overrides the normal flow.
  always_comb begin
    fsm_nxt_s   = state_r;
    abort_hit_s = abort && (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (start) fsm_nxt_s = CLEAR;
        else       fsm_nxt_s = IDLE;
      end
      CLEAR: begin
        if (len_r == {AW{1'b0}}) fsm_nxt_s = FIN;
        else                     fsm_nxt_s = FETCH;
      end
      FETCH: begin
        if (rem_r == AW'(1)) fsm_nxt_s = DRAIN;
        else                 fsm_nxt_s = FETCH;
      end
      DRAIN: begin
        if (dcnt_r == {DCW{1'b0}}) fsm_nxt_s = FIN;
        else                       fsm_nxt_s = DRAIN;
      end
      FIN:     fsm_nxt_s = IDLE;
      default: fsm_nxt_s = IDLE;
    endcase
    if (abort_hit_s) state_nxt_s = IDLE;
    else             state_nxt_s = fsm_nxt_s;
  end

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      mac_clr  <= 1'b0;
      valid_r  <= 1'b0;
      result   <= {ACCW{1'b0}};
      addr_a   <= {AW{1'b0}};
      addr_b   <= {AW{1'b0}};
      base_a_r <= {AW{1'b0}};
      base_b_r <= {AW{1'b0}};
      len_r    <= {AW{1'b0}};
      rem_r    <= {AW{1'b0}};
      dcnt_r   <= {DCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      rd_en   <= (state_nxt_s == FETCH);
      mac_clr <= (state_nxt_s == CLEAR);
      done    <= (state_r == FIN) && !abort_hit_s;
      // A read issued in the abort cycle must not reach the MAC.
      valid_r <= rd_en && (state_nxt_s != IDLE);

      if ((state_r == IDLE) && start) begin
        base_a_r <= base_a;
        base_b_r <= base_b;
        len_r    <= len;
      end

      if (state_r == CLEAR) begin
        addr_a <= base_a_r;
        addr_b <= base_b_r;
        rem_r  <= len_r;
      end else if ((state_r == FETCH) && (state_nxt_s == FETCH)) begin
        addr_a <= addr_a + AW'(1);
        addr_b <= addr_b + AW'(1);
        rem_r  <= rem_r - AW'(1);
      end

      if (state_r == FETCH) dcnt_r <= DCW'(MAC_LAT - 1);
      else if (state_r == DRAIN) dcnt_r <= dcnt_r - DCW'(1);

      if ((state_r == FIN) && !abort_hit_s) begin
        if (len_r == {AW{1'b0}}) result <= {ACCW{1'b0}};
        else                     result <= mac_acc;
      end
    end
  end

  assign mac_a = valid_r ? rd_data_a : {DW{1'b0}};
  assign mac_b = valid_r ? rd_data_b : {DW{1'b0}};

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural MAC and two sync-read
// operand memories; expected sums are hand-computed constants.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  base_a, base_b, len;
  logic        busy, done, rd_en, mac_clr;
  logic [35:0] result;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [15:0] mac_a, mac_b;
  logic [35:0] mac_acc;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  int errors = 0;
  int checks = 0;
  int done_cyc, rd_cnt, busy_first, busy_last, clr_cyc, cnt;
  logic [7:0] addrs [$];

  mac_dot_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy), .done(done), .result(result),
    .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc)
  );

  always #5 clk = ~clk;

  // Sync-read operand memories
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[addr_a];
      rd_data_b <= mem_b[addr_b];
    end
  end

  // External MAC, one cycle of latency, cleared by mac_clr
  always @(posedge clk) begin
    if (mac_clr) mac_acc <= 36'd0;
    else         mac_acc <= mac_acc + 36'(mac_a) * 36'(mac_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {60'd0, busy, done, rd_en, mac_clr}, 64'd0);
    chk({tag, "_result"}, {28'd0, result}, 64'd0);
    chk({tag, "_addr"}, {48'd0, addr_a, addr_b}, 64'd0);
    chk({tag, "_mac"}, {32'd0, mac_a, mac_b}, 64'd0);
  endtask

  // Runs one job; cycle 1 is the first cycle after the accepting edge.
  task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                         input bit chained, input bit chain_next, input int poke_at);
    int k;
    if (!chained) begin
      base_a = ba; base_b = bb; len = ln; start = 1'b1;
    end
    tick();
    start = 1'b0;
    k = 1; done_cyc = -1; rd_cnt = 0; busy_first = -1; busy_last = -1; clr_cyc = -1;
    addrs.delete();
    while ((k < 300) && (done_cyc < 0)) begin
      if (busy) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (mac_clr && (clr_cyc < 0)) clr_cyc = k;
      if (rd_en) begin
        rd_cnt++;
        addrs.push_back(addr_a);
      end
      if (done) begin
        done_cyc = k;
        if (chain_next) start = 1'b1;
      end else begin
        if (k == poke_at) begin
          start = 1'b1; len = 8'd0;
        end else begin
          start = 1'b0;
        end
        tick();
        k++;
      end
    end
    chk("job_terminated", {63'd0, done_cyc >= 0}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; abort = 1'b0;
    base_a = 8'd0; base_b = 8'd0; len = 8'd4;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'd0; mem_b[i] = 16'd0;
    end

    // 1: reset with start held high
    tick(); tick();
    chk_zero("in_reset");
    reset = 1'b0; start = 1'b0;
    tick();
    chk_zero("after_reset");

    // 2: {1,2,3,4}.{5,6,7,8}, with a start pulse while busy
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 16'(i + 1); mem_b[i] = 16'(i + 5);
    end
    run_job(8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 3);
    chk("t2_result", {28'd0, result}, 64'd70);
    chk("t2_done_cyc", 64'(done_cyc), 64'd8);
    chk("t2_rd_cnt", 64'(rd_cnt), 64'd4);
    chk("t2_busy_first", 64'(busy_first), 64'd1);
    chk("t2_busy_last", 64'(busy_last), 64'd7);
    chk("t2_clr_cyc", 64'(clr_cyc), 64'd1);
    tick(); tick(); tick();
    chk("t2_no_restart", {63'd0, busy}, 64'd0);

    // 4a: address wrap
    mem_a[254] = 16'd1; mem_a[255] = 16'd2; mem_a[0] = 16'd3; mem_a[1] = 16'd4;
    for (int i = 10; i < 14; i++) mem_b[i] = 16'd1;
    run_job(8'd254, 8'd10, 8'd4, 1'b0, 1'b0, -1);
    chk("t4_addr0", {56'd0, addrs[0]}, 64'd254);
    chk("t4_addr1", {56'd0, addrs[1]}, 64'd255);
    chk("t4_addr2", {56'd0, addrs[2]}, 64'd0);
    chk("t4_addr3", {56'd0, addrs[3]}, 64'd1);
    chk("t4_result", {28'd0, result}, 64'd10);

    // 4b: zero length
    run_job(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, -1);
    chk("t4_len0_done_cyc", 64'(done_cyc), 64'd3);
    chk("t4_len0_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("t4_len0_result", {28'd0, result}, 64'd0);

    // 3: twelve-element dot product, restarted in its done cycle
    for (int i = 0; i < 12; i++) begin
      mem_a[i] = 16'(i * i); mem_b[i] = 16'(i * i + 3 * i + 4);
    end
    run_job(8'd0, 8'd0, 8'd12, 1'b0, 1'b1, -1);
    chk("t3_result", {28'd0, result}, 64'd55066);
    chk("t3_done_cyc", 64'(done_cyc), 64'd16);
    chk("t3_done_busy", {63'd0, busy}, 64'd0);
    run_job(8'd0, 8'd0, 8'd12, 1'b1, 1'b0, -1);
    chk("t3_b2b_result", {28'd0, result}, 64'd55066);
    chk("t3_b2b_done_cyc", 64'(done_cyc), 64'd16);

    // 5: abort in FETCH cycle 3
    base_a = 8'd0; base_b = 8'd0; len = 8'd12; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t5_fetching", {63'd0, rd_en}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_ctl", {61'd0, busy, rd_en, done}, 64'd0);
    chk("t5_abort_mac", {32'd0, mac_a, mac_b}, 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) cnt++;
      tick();
    end
    chk("t5_no_done", 64'(cnt), 64'd0);
    chk("t5_result_kept", {28'd0, result}, 64'd55066);

    // 6: full-scale operands, no wrap
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'hFFFF; mem_b[i] = 16'hFFFF;
    end
    run_job(8'd0, 8'd0, 8'd16, 1'b0, 1'b0, -1);
    chk("t6_result", {28'd0, result}, 64'd68717379600);
    chk("t6_done_cyc", 64'(done_cyc), 64'd20);

    // 6b: reset in the middle of a job
    base_a = 8'd0; base_b = 8'd0; len = 8'd16; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    chk_zero("midjob_reset");
    reset = 1'b0;
    tick();
    chk_zero("midjob_after");
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) cnt++;
      tick();
    end
    chk("t6_no_job_after_reset", 64'(cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
